mem_access_adapter: RTL
=======================

# mem_access_adapter

Byte-addressed load/store front end for the bench word RAM. Accepts one request at a time from the core's data port and converts the byte address and access size into word-index accesses. Generates byte write masks and lane-shifts write data, and splits misaligned accesses that cross a word boundary into two word accesses. Assembles and sign/zero-extends read data, and raises the sticky `sim_done` that ends a compliance run when the core writes the tohost word.

## Interface
- `TOHOST_ADDR`, 32'h8000_1000: byte address of the tohost word; word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: adapter can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle pulse; load data or store completion.
- `rsp_rdata` out 32: extended load data; 0 for stores.
- `mem_addr` out 32: word index to RAM, `{2'b00, byte_addr[31:2]}`.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_wmask` out 4: byte write enables.
- `mem_rdata` in 32: RAM read data, combinational on `mem_addr`.
- `sim_done` out 1: sticky end-of-test flag.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture we, addr, size, unsigned and wdata; go to ACC0.
- **Lane computation** (from captured request, offset `off = addr[1:0]`)
  - `smask` = 4'b0001 / 4'b0011 / 4'b1111 for byte / half / word.
  - 8-bit `lmask = smask << off`.
  - 64-bit `lwdata = wdata << (8*off)`.
  - `split = |lmask[7:4]`.
- **ACC0**
  - `mem_addr` = word(addr).
  - `mem_wmask` = `lmask[3:0]` if store, else 0.
  - `mem_wdata` = `lwdata[31:0]`.
  - Load: latch `mem_rdata` into `lo`.
  - Next state: ACC1 if `split`, else RESP.
- **ACC1**
  - `mem_addr` = word(addr)+1, wrapping mod 2^30.
  - `mem_wmask` = `lmask[7:4]` if store, else 0.
  - `mem_wdata` = `lwdata[63:32]`.
  - Load: latch `mem_rdata` into `hi`.
  - Next state: RESP.
- **RESP**
  - `rsp_valid`=1.
  - Load: `rsp_rdata` = `({hi,lo} >> 8*off)` truncated to the size, then sign- or zero-extended to 32 bits. `hi` is 0 when not split.
  - Next state: IDLE.
- **Idle outputs**: in IDLE and RESP, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0.
- **tohost detection**
  - Condition: in ACC0, store with size word, `addr == TOHOST_ADDR` and `wdata[0]==1`.
  - Action: `sim_done` is set on that clock edge and stays set until `rst`.
  - The store is still performed.
  - An unaligned address never matches.
- `rsp_rdata` holds its value outside RESP.

## Timing
- **Reset**
  - Outputs: `req_ready`=0 during reset, `rsp_valid`=0, `rsp_rdata`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wmask`=0, `sim_done`=0.
  - State returns to IDLE.
  - Reset asserted in ACC0 or ACC1 aborts the access; no further mask is driven.
  - A write already clocked into the RAM is not undone.
- **Latency**
  - Aligned or non-crossing access: accepted at edge N, `rsp_valid` high during cycle N+2.
  - Crossing access: `rsp_valid` high during cycle N+3.
- **Throughput**: next request accepted the edge after RESP; `req_ready` low from ACC0 through RESP.
- **Write commit**
  - `mem_wmask` is asserted for exactly one cycle per touched word.
  - The RAM commits on the edge ending that cycle.
  - For a crossing store, the low word commits before the high word.
- **Read sampling**: `mem_rdata` is sampled at the end of ACC0/ACC1, so the RAM must be combinational-read.
- **Protocol rule**: the requester holds `req_*` stable only until acceptance; later changes are ignored.

## Test plan
- Aligned word store then load, addr 0x100, data 0xDEADC0DE -> ACC0 `mem_addr`=0x40, `mem_wmask`=4'hF; load returns 0xDEADC0DE at accept+2.
- Byte store 0x80 at 0x103, then signed byte load at 0x103 -> `mem_wmask`=4'b1000, `mem_wdata`=0x80000000; `rsp_rdata`=0xFFFFFF80. Unsigned load -> 0x00000080.
- Crossing word store 0x11223344 at 0x102 -> ACC0 word 0x40, mask 4'b1100, wdata 0x33440000; ACC1 word 0x41, mask 4'b0011, wdata 0x00001122. Load at 0x102 returns 0x11223344 at accept+3.
- Crossing signed half load at 0x203 with word 0x80=0xAB000000 and word 0x81=0x000000FF -> `rsp_rdata`=0xFFFFFFAB... assembled half 0xFFAB, sign-extended to 0xFFFFFFAB.
- Word store 0x1 to `TOHOST_ADDR` -> `sim_done` rises after ACC0 and stays high. A store of 0x0, a half store, or an unaligned store to that address leaves it low.
- Assert `rst` during ACC0 of a crossing store -> next cycle all outputs are 0 and state is IDLE; the high word is never written.

Source files
------------

// File: rtl/mem_access_adapter.sv
// mem_access_adapter: byte-addressed load/store front end for the word RAM.
// Splits word-crossing accesses in two, extends load data, and flags tohost writes.
module mem_access_adapter #(
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    output logic        sim_done
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
    state_t state, state_nxt;
    logic        we, uns;
    logic [31:0] addr, wdata, lo, hi, rdata_hold, rdata_ext, rshift;
    logic [1:0]  size, off;
    logic [3:0]  smask;
    logic [7:0]  lmask;
    logic [63:0] lwdata;
    logic [29:0] word;
    logic        split;
    assign off    = addr[1:0];
    assign word   = addr[31:2];
    assign smask  = (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    assign lmask  = {4'b0000, smask} << off;
    assign lwdata = {32'b0, wdata} << {off, 3'b000};
    assign split  = |lmask[7:4];
    // hi stays zero for non-crossing loads, so one shift covers both cases
    assign rshift = 32'({hi, lo} >> {off, 3'b000});
    assign rdata_ext = (size == 2'd0) ? {{24{rshift[7] & ~uns}}, rshift[7:0]} :
                       (size == 2'd1) ? {{16{rshift[15] & ~uns}}, rshift[15:0]} : rshift;
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = rst ? 32'b0 : rdata_hold;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        mem_wmask = 4'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    req_ready = 1'b1;
                    state_nxt = req_valid ? ACC0 : IDLE;
                end
                ACC0: begin
                    mem_addr  = {2'b00, word};
                    mem_wmask = we ? lmask[3:0] : 4'b0;
                    mem_wdata = lwdata[31:0];
                    state_nxt = split ? ACC1 : RESP;
                end
                ACC1: begin
                    mem_addr  = {2'b00, word + 30'd1};
                    mem_wmask = we ? lmask[7:4] : 4'b0;
                    mem_wdata = lwdata[63:32];
                    state_nxt = RESP;
                end
                default: begin
                    rsp_valid = 1'b1;
                    rsp_rdata = we ? 32'b0 : rdata_ext;
                    state_nxt = IDLE;
                end
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we         <= 1'b0;
            uns        <= 1'b0;
            addr       <= 32'b0;
            size       <= 2'b0;
            wdata      <= 32'b0;
            lo         <= 32'b0;
            hi         <= 32'b0;
            rdata_hold <= 32'b0;
            sim_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                we    <= req_we;
                uns   <= req_unsigned;
                addr  <= req_addr;
                size  <= req_size;
                wdata <= req_wdata;
                hi    <= 32'b0;
            end
            if (state == ACC0 && !we) lo <= mem_rdata;
            if (state == ACC1 && !we) hi <= mem_rdata;
            if (state == RESP) rdata_hold <= rsp_rdata;
            if (state == ACC0 && we && size[1] && addr == TOHOST_ADDR && wdata[0]) sim_done <= 1'b1;
        end
    end
endmodule
